// File: rtl/mem_burst_sequencer.sv
// mem_burst_sequencer: multi-word load/store sequencer between the register
// files and the single-port data memory. Beat 0 is issued combinationally in
// the request cycle; later beats run in XFER with the PC held via stall.
// Optional build macro MEM_WAIT_EN adds a mem_ready handshake that stretches
// any beat (including the final one) until the memory accepts it.
`timescale 1ns/1ps

module mem_burst_sequencer #(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 7,
  parameter int unsigned RW        = 5,
  parameter int unsigned MAX_BEATS = 4,
  localparam int unsigned CW       = $clog2(MAX_BEATS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_load,
  input  logic          req_store,
  input  logic [CW-1:0] nwords,
  input  logic [AW-1:0] base_addr,
  input  logic [RW-1:0] reg_base,
  input  logic [DW-1:0] rd_data,
  input  logic [DW-1:0] mem_rdata,
`ifdef MEM_WAIT_EN
  input  logic          mem_ready,
`endif
  output logic [AW-1:0] mem_addr,
  output logic          mem_en,
  output logic          mem_we,
  output logic          mem_re,
  output logic [DW-1:0] mem_wdata,
  output logic [RW-1:0] reg_idx,
  output logic          reg_we,
  output logic [DW-1:0] reg_wdata,
  output logic          stall,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [0:0] {
    StIdle,
    StXfer
  } state_e;

  localparam logic [CW-1:0] MaxBeats = CW'(MAX_BEATS);

  state_e        state_q, state_d;
  logic [CW-1:0] beat_q, beat_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          ready;
  logic          req;
  logic          is_load;
  logic          is_store;
  logic [CW-1:0] n_eff;
  logic [CW:0]   beat_inc;
  logic          last_beat;
  logic          access;
  logic          stall_c;

`ifdef MEM_WAIT_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  // Simultaneous requests resolve to a load; the conflict is flagged via err.
  assign req      = req_load | req_store;
  assign is_load  = req_load;
  assign is_store = req_store & ~req_load;

  assign n_eff     = (nwords > MaxBeats) ? MaxBeats : nwords;
  assign beat_inc  = {1'b0, beat_q} + {{CW{1'b0}}, 1'b1};
  // Compare with >= so a stray short nwords mid-burst still terminates.
  assign last_beat = (beat_inc >= {1'b0, n_eff});

  // Next-state logic: beat sequencing, abort on dropped request, done/err.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    err_d   = err_q | (req_load & req_store);
    access  = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          if (n_eff == '0) begin
            done_d = 1'b1;
          end else begin
            access = 1'b1;
            if (!ready) begin
              stall_c = 1'b1;
            end else if (last_beat) begin
              done_d = 1'b1;
            end else begin
              stall_c = 1'b1;
              state_d = StXfer;
              beat_d  = beat_inc[CW-1:0];
            end
          end
        end
      end
      StXfer: begin
        if (!req) begin
          state_d = StIdle;
          beat_d  = '0;
        end else begin
          access = 1'b1;
          if (!ready) begin
            stall_c = 1'b1;
          end else if (last_beat) begin
            state_d = StIdle;
            beat_d  = '0;
            done_d  = 1'b1;
          end else begin
            stall_c = 1'b1;
            beat_d  = beat_inc[CW-1:0];
          end
        end
      end
      default: begin
        state_d = StIdle;
        beat_d  = '0;
      end
    endcase
  end

  // State, beat counter and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      beat_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    mem_addr  = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = '0;
    reg_idx   = '0;
    reg_we    = 1'b0;
    reg_wdata = '0;
    stall     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    if (rst_n) begin
      mem_wdata = rd_data;
      reg_wdata = mem_rdata;
      stall     = stall_c;
      busy      = (state_q == StXfer);
      done      = done_q;
      err       = err_q;
      if (access) begin
        mem_en   = 1'b1;
        mem_re   = is_load;
        mem_we   = is_store;
        reg_we   = is_load & ready;
        // Address and register index wrap naturally at their widths.
        mem_addr = base_addr + AW'(beat_q);
        reg_idx  = reg_base + RW'(beat_q);
      end
    end
  end

endmodule
